// File: rtl/idma_axi_b_collector.sv
// iDMA AXI backend write-response collector: matches in-order B responses against
// per-burst meta and emits one completion record per 1D transfer.
module idma_axi_b_collector #(
  parameter int NumOutstanding = 16,
  parameter int CntWidth       = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              meta_valid_i,
  output logic                              meta_ready_o,
  input  logic                              meta_last_i,
  input  logic                              meta_super_last_i,
  input  logic                              b_valid_i,
  output logic                              b_ready_o,
  input  logic [1:0]                        b_resp_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic                              rsp_error_o,
  output logic [1:0]                        rsp_resp_o,
  output logic [CntWidth-1:0]               rsp_num_bursts_o,
  output logic                              rsp_super_last_o,
  output logic [$clog2(NumOutstanding):0]   outstanding_o,
  output logic                              busy_o
);
  localparam int PtrW = $clog2(NumOutstanding);

  logic [1:0]          mem [NumOutstanding];
  logic [PtrW-1:0]     wptr, rptr;
  logic [PtrW:0]       level;
  logic                full, nonempty, head_last, head_sl, push, pop;

  logic [CntWidth-1:0] acc_cnt, cnt_inc;
  logic                acc_err, err_nxt;
  logic [1:0]          acc_resp, resp_nxt;

  assign full      = level == (PtrW+1)'(NumOutstanding);
  assign nonempty  = level != '0;
  assign head_last = mem[rptr][1];
  assign head_sl   = mem[rptr][0];

  assign meta_ready_o = !full;
  assign b_ready_o    = nonempty & (!head_last | !rsp_valid_o | rsp_ready_i);
  assign push         = meta_valid_i & meta_ready_o;
  assign pop          = b_valid_i & b_ready_o;

  // Saturating count; only the first erroneous BRESP of a transfer is kept.
  assign cnt_inc  = (&acc_cnt) ? acc_cnt : acc_cnt + 1'b1;
  assign err_nxt  = acc_err | b_resp_i[1];
  assign resp_nxt = acc_err ? acc_resp : (b_resp_i[1] ? b_resp_i : 2'b00);

  assign outstanding_o = level;
  assign busy_o        = nonempty | (acc_cnt != '0) | rsp_valid_o;

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= {meta_last_i, meta_super_last_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr             <= '0;
      rptr             <= '0;
      level            <= '0;
      acc_cnt          <= '0;
      acc_err          <= 1'b0;
      acc_resp         <= 2'b00;
      rsp_valid_o      <= 1'b0;
      rsp_error_o      <= 1'b0;
      rsp_resp_o       <= 2'b00;
      rsp_num_bursts_o <= '0;
      rsp_super_last_o <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (pop && head_last) begin
        rsp_valid_o      <= 1'b1;
        rsp_error_o      <= err_nxt;
        rsp_resp_o       <= resp_nxt;
        rsp_num_bursts_o <= cnt_inc;
        rsp_super_last_o <= head_sl;
        acc_cnt          <= '0;
        acc_err          <= 1'b0;
        acc_resp         <= 2'b00;
      end else begin
        if (rsp_ready_i) rsp_valid_o <= 1'b0;
        if (pop) begin
          acc_cnt  <= cnt_inc;
          acc_err  <= err_nxt;
          acc_resp <= resp_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_idma_axi_b_collector.sv
// Cycle-by-cycle check of idma_axi_b_collector against a transfer-level model
// built on a meta queue; directed scenarios followed by randomized traffic.
module tb_idma_axi_b_collector;
  localparam int NO = 16;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, meta_valid, meta_ready, meta_last, meta_super_last;
  logic b_valid, b_ready, rsp_valid, rsp_ready, rsp_error, rsp_super_last, busy;
  logic [1:0] b_resp, rsp_resp;
  logic [CW-1:0] rsp_num_bursts;
  logic [$clog2(NO):0] outstanding;

  always #5 clk = ~clk;

  idma_axi_b_collector #(.NumOutstanding(NO), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .meta_valid_i(meta_valid), .meta_ready_o(meta_ready),
    .meta_last_i(meta_last), .meta_super_last_i(meta_super_last),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_error_o(rsp_error), .rsp_resp_o(rsp_resp),
    .rsp_num_bursts_o(rsp_num_bursts), .rsp_super_last_o(rsp_super_last),
    .outstanding_o(outstanding), .busy_o(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  typedef struct { bit last; bit sl; } meta_t;
  meta_t q[$];
  int    acc_n;
  bit    acc_e;
  bit [1:0] acc_r;
  bit    o_v, o_e, o_sl;
  bit [1:0] o_r;
  int    o_n;

  function automatic void model_reset();
    q.delete();
    acc_n = 0; acc_e = 0; acc_r = 0;
    o_v = 0; o_e = 0; o_r = 0; o_n = 0; o_sl = 0;
  endfunction

  // Drive one cycle of inputs, compare outputs against the model, then advance the model.
  task automatic step(input bit r, input bit mv, input bit ml, input bit msl,
                      input bit bv, input bit [1:0] br, input bit rr);
    bit full, mrdy, hl, brdy, push, pop;
    meta_t m;
    @(posedge clk); #1;
    rst = r; meta_valid = mv; meta_last = ml; meta_super_last = msl;
    b_valid = bv; b_resp = br; rsp_ready = rr;
    #1;
    full = q.size() == NO;
    mrdy = !full;
    hl   = (q.size() != 0) && q[0].last;
    brdy = (q.size() != 0) && (!hl || !o_v || rr);
    chk("meta_ready", 32'(meta_ready), 32'(mrdy));
    chk("b_ready", 32'(b_ready), 32'(brdy));
    chk("outstanding", 32'(outstanding), 32'(q.size()));
    chk("busy", 32'(busy), 32'((q.size() != 0) || (acc_n != 0) || o_v));
    chk("rsp_valid", 32'(rsp_valid), 32'(o_v));
    chk("rsp_error", 32'(rsp_error), 32'(o_e));
    chk("rsp_resp", 32'(rsp_resp), 32'(o_r));
    chk("rsp_num_bursts", 32'(rsp_num_bursts), 32'(o_n));
    chk("rsp_super_last", 32'(rsp_super_last), 32'(o_sl));
    if (r) begin
      model_reset();
      return;
    end
    push = mv && mrdy;
    pop  = bv && brdy;
    if (pop) begin
      int n;
      bit e;
      bit [1:0] rs;
      m  = q.pop_front();
      n  = (acc_n + 1 > CMAX) ? CMAX : acc_n + 1;
      e  = acc_e || br[1];
      rs = acc_e ? acc_r : (br[1] ? br : 2'b00);
      if (m.last) begin
        o_v = 1; o_e = e; o_r = rs; o_n = n; o_sl = m.sl;
        acc_n = 0; acc_e = 0; acc_r = 0;
      end else begin
        if (rr) o_v = 0;
        acc_n = n; acc_e = e; acc_r = rs;
      end
    end else if (rr) o_v = 0;
    if (push) begin
      m.last = ml; m.sl = msl;
      q.push_back(m);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 2'b00, 1);
  endtask

  initial begin
    rst = 1; meta_valid = 0; meta_last = 0; meta_super_last = 0;
    b_valid = 0; b_resp = 0; rsp_ready = 0;
    model_reset();
    step(1, 0, 0, 0, 0, 2'b00, 0);
    step(1, 0, 0, 0, 0, 2'b00, 0);
    idle(1);
    // Three-burst transfer, all OKAY
    step(0, 1, 0, 1, 0, 2'b00, 0);
    step(0, 1, 0, 1, 0, 2'b00, 0);
    step(0, 1, 1, 1, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 2'b00, 0);
    step(0, 0, 0, 0, 0, 2'b00, 1);
    idle(2);
    // Error aggregation: {OKAY, SLVERR, DECERR} then {EXOKAY}
    step(0, 1, 0, 0, 0, 2'b00, 1);
    step(0, 1, 0, 0, 0, 2'b00, 1);
    step(0, 1, 1, 0, 0, 2'b00, 1);
    step(0, 1, 1, 1, 0, 2'b00, 1);
    step(0, 0, 0, 0, 1, 2'b00, 1);
    step(0, 0, 0, 0, 1, 2'b10, 1);
    step(0, 0, 0, 0, 1, 2'b11, 1);
    step(0, 0, 0, 0, 1, 2'b01, 1);
    idle(2);
    // B with empty FIFO, then in the cycle of the first push
    step(0, 0, 0, 0, 1, 2'b00, 1);
    step(0, 1, 1, 0, 1, 2'b00, 1);
    step(0, 0, 0, 0, 1, 2'b00, 1);
    idle(2);
    // Fill FIFO, attempt push while full and popping
    for (int i = 0; i < NO + 1; i++) step(0, 1, 0, 0, 0, 2'b00, 1);
    step(0, 1, 1, 0, 1, 2'b00, 1);
    step(0, 1, 1, 0, 0, 2'b00, 1);
    for (int i = 0; i < NO + 2; i++) step(0, 0, 0, 0, 1, 2'b00, 1);
    idle(2);
    // Backpressure on last-burst B while output register is full
    step(0, 1, 1, 0, 0, 2'b00, 0);
    step(0, 1, 1, 1, 0, 2'b00, 0);
    step(0, 0, 0, 0, 1, 2'b00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 2'b10, 0);
    step(0, 0, 0, 0, 1, 2'b10, 1);
    step(0, 0, 0, 0, 0, 2'b00, 1);
    idle(2);
    // Reset after 2 of 4 bursts, then a fresh single-burst transfer
    for (int i = 0; i < 4; i++) step(0, 1, i == 3, 0, 0, 2'b00, 1);
    step(0, 0, 0, 0, 1, 2'b10, 1);
    step(0, 0, 0, 0, 1, 2'b00, 1);
    step(1, 0, 0, 0, 0, 2'b00, 1);
    step(0, 1, 1, 0, 1, 2'b00, 1);
    step(0, 0, 0, 0, 1, 2'b00, 1);
    idle(3);
    // Saturation: ten-burst transfer with a 3-bit counter
    for (int i = 0; i < 10; i++) step(0, 1, i == 9, 1, 0, 2'b00, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 2'b00, 1);
    idle(2);
    // Randomized traffic with shifting biases
    for (int i = 0; i < 4000; i++) begin
      int ph;
      ph = (i / 500) % 4;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) < (ph == 1 ? 3 : 2)),
           ($urandom_range(0, 4) == 0),
           1'($urandom),
           ($urandom_range(0, 3) < (ph == 1 ? 1 : 2)),
           2'($urandom),
           ($urandom_range(0, 3) < (ph == 2 ? 1 : 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
